regfile_dump_sequencer: RTL and testbench
=========================================

# regfile_dump_sequencer

Debug-side controller for the CPU register file: on a start pulse it walks a configurable address range over the register file's debug read port, generating the debug read address and debug clock pulse, capturing each 32-bit word, and streaming it out as bytes on a valid/ready interface toward the debug UART transmitter. It sits between the register file's debug port and the board-level debug serializer. It never touches the normal read/write ports, so it can run while the core executes.

## Interface
- FIRST_REG, default 0, first register address dumped (0..31)
- LAST_REG, default 31, last register address dumped (FIRST_REG..31)
- DBG_WAIT, default 1, cycles between the debug clock pulse and data capture (>=1)

- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- start  input  1  request a dump; sampled only in IDLE
- busy  output  1  high from the cycle after start is accepted through the last byte handshake
- done  output  1  one-cycle pulse after the final byte is accepted
- dbg_addr  output  5  register file debug read address
- dbg_clock  output  1  register file debug clock; registered, one-cycle high pulse per word
- dbg_data  input  32  register file debug read data
- byte_valid  output  1  byte_data is valid
- byte_ready  input  1  consumer accepts byte when byte_valid && byte_ready at a rising edge
- byte_data  output  8  streamed byte

## Operation
- States: IDLE, SETUP, PULSE, WAIT, CAPTURE, SEND, DONE.
- IDLE: outputs idle; start=1 -> SETUP, address counter <= FIRST_REG.
- SETUP: dbg_addr = counter, dbg_clock=0 (address settles one cycle before the edge) -> PULSE.
- PULSE: dbg_clock=1 for exactly one cycle -> WAIT, wait counter <= DBG_WAIT.
- WAIT: dbg_clock=0; decrement; at 1 -> CAPTURE.
- CAPTURE: latch dbg_data into 32-bit shift register, byte index <= 0 -> SEND.
- SEND: byte_data = shift register bits [31:24] (MSB first); on handshake shift left 8, increment index; after 4th handshake: if counter == LAST_REG -> DONE, else counter+1 -> SETUP.
- DONE: done=1, busy=0 for one cycle -> IDLE.
- Reset values: busy=0, done=0, dbg_addr=0, dbg_clock=0, byte_valid=0, byte_data=0, state IDLE.
- dbg_addr held constant from SETUP through CAPTURE of each word.
- Counter is 5 bits; LAST_REG=31 terminates by compare, never wraps.

## Timing
- start sampled at edge E in IDLE: SETUP in cycle E+1, PULSE E+2, WAIT E+3..E+2+DBG_WAIT, CAPTURE E+3+DBG_WAIT, byte_valid=1 from E+4+DBG_WAIT.
- With byte_ready held high: one byte per cycle; per-word overhead 3+DBG_WAIT cycles; default full dump 32*(4+4)=256 cycles plus DONE.
- byte_valid, once high, stays high and byte_data stable until handshake (no retraction).
- start while not in IDLE (including DONE cycle): ignored, no queuing.
- byte_ready while byte_valid=0: no effect.
- reset mid-operation: at next edge all outputs to reset values, state IDLE, partially sent word discarded; dbg_clock pulse never extended.
- start and reset same edge: reset wins.

## Configuration
- REGFILE_DUMP_HEADER_EN defined: each word preceded by header byte {3'b101, addr[4:0]} sent in SEND before the 4 data bytes (5 bytes/word, header first); default full dump 160 bytes.
- Undefined: 4 data bytes per word, no header; 128 bytes per default dump.

## Test plan
- Register file reset (reg i = i), default params, byte_ready=1, pulse start -> 128 bytes; reg 5 yields 00 00 00 05, reg 31 yields 00 00 00 1F; done pulses once; busy low afterwards.
- Load reg 29 = 0x0000007C, reg 3 = 0xDEADBEEF; FIRST_REG=3, LAST_REG=3 -> exactly DE AD BE EF, dbg_clock pulses once with dbg_addr=3.
- Random byte_ready backpressure (~50%) on default dump -> byte stream identical to no-backpressure run; byte_data never changes while valid && !ready.
- start re-pulsed during busy and in DONE cycle -> ignored, single 128-byte dump.
- Assert reset after 10 bytes -> next cycle byte_valid=0, busy=0, dbg_clock=0; fresh start reproduces full dump from reg 0.
- REGFILE_DUMP_HEADER_EN, FIRST_REG=29, LAST_REG=30 -> BD 00 00 00 7C BE 00 00 00 1E (reg 30 = 30 after reset, reg 29 loaded 0x7C).

Source files
------------

// File: rtl/regfile_dump_sequencer.sv
// rtl/regfile_dump_sequencer.sv - walks a register-file address range over the debug port and streams each word as bytes
//
// Parameters:
//   FIRST_REG  first register address dumped (0..31)
//   LAST_REG   last register address dumped (FIRST_REG..31)
//   DBG_WAIT   cycles between the debug clock pulse and data capture (>=1)
// Optional build macro:
//   REGFILE_DUMP_HEADER_EN  prefix every word with a header byte {3'b101, addr[4:0]}
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               dump request, sampled only while idle
//   busy, done          dump in progress / one-cycle completion pulse
//   dbg_addr, dbg_clock register file debug read address and debug clock pulse
//   dbg_data            register file debug read data
//   byte_valid, byte_ready, byte_data  byte stream toward the debug serializer
module regfile_dump_sequencer #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31,
    parameter int DBG_WAIT  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  dbg_addr,
    output logic        dbg_clock,
    input  logic [31:0] dbg_data,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_PULSE   = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_CAPTURE = 3'd4;
    localparam logic [2:0] S_SEND    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

`ifdef REGFILE_DUMP_HEADER_EN
    localparam int NBYTES = 5;
`else
    localparam int NBYTES = 4;
`endif
    localparam int SW = 8 * NBYTES;

    localparam logic [4:0]  FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0]  LAST_ADDR  = 5'(LAST_REG);
    localparam logic [15:0] WAIT_INIT  = 16'(DBG_WAIT);
    localparam logic [2:0]  LAST_IDX   = 3'(NBYTES - 1);

    logic [2:0]    state;
    logic [4:0]    addr_cnt;
    logic [15:0]   wait_cnt;
    logic [2:0]    byte_idx;
    logic [SW-1:0] shift_q;
    logic [SW-1:0] load_word;

    // The header (when built in) rides at the top of the shift register so
    // it leaves first through the same MSB-first byte path as the data.
`ifdef REGFILE_DUMP_HEADER_EN
    assign load_word = {3'b101, addr_cnt, dbg_data};
`else
    assign load_word = dbg_data;
`endif

    // The address counter only moves on start and between words, so the
    // debug address is stable from SETUP through CAPTURE.
    assign dbg_addr  = addr_cnt;
    assign byte_data = shift_q[SW-1 -: 8];

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            addr_cnt   <= 5'd0;
            wait_cnt   <= 16'd0;
            byte_idx   <= 3'd0;
            shift_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dbg_clock  <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            // Single-cycle pulses default low every cycle.
            dbg_clock <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_SETUP;
                        addr_cnt <= FIRST_ADDR;
                        busy     <= 1'b1;
                    end
                end
                S_SETUP: begin
                    // Registered so the pulse appears in the PULSE cycle,
                    // one cycle after the address settled.
                    state     <= S_PULSE;
                    dbg_clock <= 1'b1;
                end
                S_PULSE: begin
                    state    <= S_WAIT;
                    wait_cnt <= WAIT_INIT;
                end
                S_WAIT: begin
                    if (wait_cnt <= 16'd1) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt - 16'd1;
                    end
                end
                S_CAPTURE: begin
                    shift_q    <= load_word;
                    byte_idx   <= 3'd0;
                    byte_valid <= 1'b1;
                    state      <= S_SEND;
                end
                S_SEND: begin
                    if (byte_ready) begin
                        shift_q  <= {shift_q[SW-9:0], 8'h00};
                        byte_idx <= byte_idx + 3'd1;
                        if (byte_idx == LAST_IDX) begin
                            byte_valid <= 1'b0;
                            // Compare-terminated: LAST_REG=31 never wraps.
                            if (addr_cnt == LAST_ADDR) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                addr_cnt <= addr_cnt + 5'd1;
                                state    <= S_SETUP;
                            end
                        end
                    end
                end
                S_DONE: begin
                    // start is deliberately not looked at here.
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// tb/tb_regfile_dump_sequencer.sv - randomized self-checking bench for regfile_dump_sequencer
module tb_regfile_dump_sequencer;

`ifdef REGFILE_DUMP_HEADER_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic clock;
    logic reset;
    logic [2:0] start;
    logic [2:0] byte_ready;
    logic [2:0] busy, done, dbg_clock, byte_valid;
    logic [2:0][4:0] daddr;
    logic [2:0][7:0] bdata;

    logic [31:0] regs [32];

    int checks = 0;
    int failures = 0;

    // scoreboard state
    int active = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx [$];
    logic [7:0] ref_q [$];
    bit rand_ready = 0;
    bit prev_stall = 0;
    bit prev_dbg = 0;
    logic [7:0] prev_data = 8'h00;
    int pulse_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [4:0] last_pulse_addr = 5'd0;

    function automatic int first_of(input int g);
        return (g == 0) ? 0 : (g == 1) ? 3 : 29;
    endfunction
    function automatic int last_of(input int g);
        return (g == 0) ? 31 : (g == 1) ? 3 : 30;
    endfunction
    function automatic int wait_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : 3;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int F = (g == 0) ? 0 : (g == 1) ? 3 : 29;
            localparam int L = (g == 0) ? 31 : (g == 1) ? 3 : 30;
            localparam int W = (g == 0) ? 1 : (g == 1) ? 2 : 3;
            logic        b, d, dc, bv;
            logic [4:0]  da;
            logic [7:0]  bd;
            logic [31:0] rf_q;

            regfile_dump_sequencer #(.FIRST_REG(F), .LAST_REG(L), .DBG_WAIT(W)) dut (
                .clock      (clock),
                .reset      (reset),
                .start      (start[g]),
                .busy       (b),
                .done       (d),
                .dbg_addr   (da),
                .dbg_clock  (dc),
                .dbg_data   (rf_q),
                .byte_valid (bv),
                .byte_ready (byte_ready[g]),
                .byte_data  (bd)
            );

            // register file debug port: read data latched on the debug clock
            always @(posedge dc) rf_q <= regs[da];

            assign busy[g]       = b;
            assign done[g]       = d;
            assign dbg_clock[g]  = dc;
            assign byte_valid[g] = bv;
            assign daddr[g]      = da;
            assign bdata[g]      = bd;
        end
    endgenerate

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        byte_ready = 3'b111;
        forever begin
            @(posedge clock);
            #1;
            if (rand_ready) byte_ready = 3'($urandom_range(0, 7));
            else            byte_ready = 3'b111;
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // per-cycle compare against the expected byte queue
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_stall = 0;
                prev_dbg = 0;
            end else begin
                for (int g = 0; g < 3; g++) begin
                    if (g != active && (byte_valid[g] || dbg_clock[g] || busy[g])) begin
                        checks++;
                        failures++;
                        $display("FAIL idle_inst%0d: valid=%0b dbg_clock=%0b busy=%0b expected all 0",
                                 g, byte_valid[g], dbg_clock[g], busy[g]);
                    end
                end
                if (byte_valid[active]) begin
                    if (prev_stall) check("hold_stable", bdata[active], prev_data);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_byte: got 0x%0h expected no byte", bdata[active]);
                    end else begin
                        check("byte", bdata[active], exp_q[0]);
                    end
                    if (byte_ready[active]) begin
                        if (exp_q.size() > 0) exp_q.delete(0);
                        rx.push_back(bdata[active]);
                    end
                end
                prev_stall = byte_valid[active] && !byte_ready[active];
                prev_data = bdata[active];
                if (dbg_clock[active]) begin
                    if (prev_dbg) check("pulse_width", 2, 1);
                    check("pulse_addr", daddr[active], first_of(active) + pulse_cnt);
                    last_pulse_addr = daddr[active];
                    pulse_cnt++;
                end
                prev_dbg = dbg_clock[active];
                if (busy[active]) busy_cnt++;
                if (done[active]) begin
                    done_cnt++;
                    if (busy[active]) check("busy_in_done", 1, 0);
                end
            end
        end
    end

    task automatic start_dump(input int g);
        int lat;
        active = g;
        exp_q.delete();
        rx.delete();
        pulse_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int a = first_of(g); a <= last_of(g); a++) begin
`ifdef REGFILE_DUMP_HEADER_EN
            exp_q.push_back({3'b101, 5'(a)});
`endif
            for (int b = 3; b >= 0; b--) exp_q.push_back(regs[a][8*b +: 8]);
        end
        @(posedge clock);
        #1 start[g] = 1'b1;
        @(posedge clock);
        #1 start[g] = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (n == 1) check("busy_after_start", busy[g], 1);
            if (n == 2) check("pulse_cycle", dbg_clock[g], 1);
            if (byte_valid[g]) begin
                lat = n;
                break;
            end
        end
        check("first_valid_latency", lat, 4 + wait_of(g));
    endtask

    task automatic wait_done(input int g, input int limit);
        bit seen = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (done[g]) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", seen, 1);
        @(negedge clock);
        check("done_one_cycle", done[g], 0);
        check("busy_after_done", busy[g], 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic compare_ref(input string name);
        int bad = 0;
        check({name, "_size"}, rx.size(), ref_q.size());
        for (int i = 0; i < rx.size() && i < ref_q.size(); i++) begin
            if (rx[i] != ref_q[i]) begin
                if (bad == 0)
                    $display("FAIL %s_byte%0d: got 0x%0h expected 0x%0h", name, i, rx[i], ref_q[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    initial begin
        reset = 1'b1;
        start = 3'b000;
        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_dbg_addr", daddr[0], 0);
        check("rst_dbg_clock", dbg_clock[0], 0);
        check("rst_byte_valid", byte_valid[0], 0);
        check("rst_byte_data", bdata[0], 0);
        @(posedge clock);
        #1 reset = 1'b0;

        // full default dump, no backpressure
        rand_ready = 0;
        start_dump(0);
        wait_done(0, 2000);
        check("full_size", rx.size(), 32 * NB);
        check("reg5_b0", rx[5*NB + NB-4], 8'h00);
        check("reg5_b3", rx[5*NB + NB-1], 8'h05);
        check("reg31_b2", rx[31*NB + NB-2], 8'h00);
        check("reg31_b3", rx[31*NB + NB-1], 8'h1F);
        check("full_busy_cycles", busy_cnt, 32 * (4 + NB));
        check("full_done_count", done_cnt, 1);
        check("full_pulse_count", pulse_cnt, 32);
        ref_q = rx;

        // same dump under random backpressure
        rand_ready = 1;
        start_dump(0);
        wait_done(0, 4000);
        compare_ref("bp_stream");
        rand_ready = 0;

        // start re-pulsed while busy and in the DONE cycle
        start_dump(0);
        repeat (50) @(negedge clock);
        start[0] = 1'b1;
        @(negedge clock);
        start[0] = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clock);
            if (done[0]) break;
        end
        start[0] = 1'b1;
        @(posedge clock);
        #1 start[0] = 1'b0;
        repeat (20) @(negedge clock);
        check("repulse_size", rx.size(), 32 * NB);
        check("repulse_done_count", done_cnt, 1);
        check("repulse_busy", busy[0], 0);

        // reset after 10 bytes, with start colliding with reset
        start_dump(0);
        for (int i = 0; i < 200 && rx.size() < 10; i++) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        @(posedge clock);
        @(negedge clock);
        check("mid_rst_valid", byte_valid[0], 0);
        check("mid_rst_busy", busy[0], 0);
        check("mid_rst_dbg_clock", dbg_clock[0], 0);
        check("mid_rst_byte_data", bdata[0], 0);
        start[0] = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        start[0] = 1'b0;
        repeat (10) @(negedge clock);
        check("rst_wins_busy", busy[0], 0);
        check("rst_wins_valid", byte_valid[0], 0);
        start_dump(0);
        wait_done(0, 2000);
        compare_ref("after_rst_stream");

        // random register contents under backpressure
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        rand_ready = 1;
        start_dump(0);
        wait_done(0, 4000);
        check("rand_size", rx.size(), 32 * NB);
        rand_ready = 0;

        for (int i = 0; i < 32; i++) regs[i] = 32'(i);
        regs[3] = 32'hDEADBEEF;
        regs[29] = 32'h0000007C;

        // single-register dump
        start_dump(1);
        wait_done(1, 500);
        check("r3_size", rx.size(), NB);
        check("r3_b0", rx[NB-4], 8'hDE);
        check("r3_b1", rx[NB-3], 8'hAD);
        check("r3_b2", rx[NB-2], 8'hBE);
        check("r3_b3", rx[NB-1], 8'hEF);
        check("r3_pulses", pulse_cnt, 1);
        check("r3_pulse_addr", last_pulse_addr, 3);

        // two-register dump 29..30
        start_dump(2);
        wait_done(2, 500);
        check("r29_size", rx.size(), 2 * NB);
`ifdef REGFILE_DUMP_HEADER_EN
        check("hdr29", rx[0], 8'hBD);
        check("hdr30", rx[5], 8'hBE);
`endif
        check("r29_b3", rx[NB-1], 8'h7C);
        check("r30_b2", rx[2*NB-2], 8'h00);
        check("r30_b3", rx[2*NB-1], 8'h1E);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
